// File: rtl/switch_encoder_16x4.sv
// switch_encoder_16x4
// Turns a 16-bit switch / one-hot bank into a 4-bit code (index of the highest
// set bit). SW is synchronized, debounced, and each newly stable value is
// reported once on a valid/ready output.
//
// Handshake: valid rises with a fresh code/multi/none and then holds them
// stable. A result is consumed at a rising edge where valid && ready. valid
// never falls without that acceptance, except on reset.
//
// state_dbg exposes the controller state (0 = IDLE, 1 = SETTLE, 2 = HOLD).
module switch_encoder_16x4 #(
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] SW,
   input  logic        enable,
   input  logic        ready,
   output logic [3:0]  code,
   output logic        valid,
   output logic        multi,
   output logic        none,
   output logic [1:0]  state_dbg
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [15:0]      s1, s2;
   logic [15:0]      committed, committed_n;
   logic [15:0]      cand, cand_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       code_n;
   logic             valid_n, multi_n, none_n;

   // Highest set bit wins; an all-zero value encodes as 0.
   function automatic logic [3:0] top_index(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves something only when two or more were set.
   function automatic logic many_bits(input logic [15:0] v);
      return (v & (v - 16'd1)) != 16'd0;
   endfunction

   assign state_dbg = state;

   // Two-flop synchronizer; only s2 is used by the debounce logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= SW;
         s2 <= s1;
      end
   end

   // Next-state, debounce bookkeeping and registered encoder results.
   always_comb begin
      state_n     = state;
      committed_n = committed;
      cand_n      = cand;
      cnt_n       = cnt;
      code_n      = code;
      valid_n     = valid;
      multi_n     = multi;
      none_n      = none;
      case (state)
         IDLE: begin
            if (enable && (s2 != committed)) begin
               state_n = SETTLE;
               cand_n  = s2;
               cnt_n   = '0;
            end
         end
         SETTLE: begin
            if (!enable) begin
               // Abort the debounce; the last accepted value stays committed.
               state_n = IDLE;
               cnt_n   = '0;
            end else if (s2 != cand) begin
               // Input moved again: restart the stability count on the new value.
               cand_n = s2;
               cnt_n  = '0;
            end else if (cnt == CNT_LAST) begin
               // Stable long enough, even if it equals the previous committed value.
               state_n     = HOLD;
               committed_n = cand;
               valid_n     = 1'b1;
               code_n      = top_index(cand);
               multi_n     = many_bits(cand);
               none_n      = (cand == 16'd0);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         HOLD: begin
            // Outputs frozen until the consumer takes them; SW and enable are ignored.
            if (valid && ready) begin
               state_n = IDLE;
               valid_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   // Controller and output registers; reset overrides every other event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         committed <= '0;
         cand      <= '0;
         cnt       <= '0;
         code      <= '0;
         valid     <= 1'b0;
         multi     <= 1'b0;
         none      <= 1'b0;
      end else begin
         state     <= state_n;
         committed <= committed_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         code      <= code_n;
         valid     <= valid_n;
         multi     <= multi_n;
         none      <= none_n;
      end
   end

endmodule

// File: tb/tb_switch_encoder_16x4.sv
// Bench for switch_encoder_16x4: directed scenarios followed by random switch
// activity, all compared cycle by cycle with a behavioural model.
module tb_switch_encoder_16x4;

   localparam int DEBOUNCE = 4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] SW = 16'h0000;
   logic        enable = 1'b0;
   logic        ready = 1'b0;
   logic [3:0]  code;
   logic        valid;
   logic        multi;
   logic        none;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   switch_encoder_16x4 #(.DEBOUNCE(DEBOUNCE)) dut (
      .clk       (clk),
      .rst       (rst),
      .SW        (SW),
      .enable    (enable),
      .ready     (ready),
      .code      (code),
      .valid     (valid),
      .multi     (multi),
      .none      (none),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [5:0] exp_q[$];   // {none, multi, code} of results not yet consumed

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The switch value seen by the detector lags SW by two edges. A value is
   // accepted once the detector has watched it for DEBOUNCE+1 consecutive
   // samples; while an accepted result waits for the consumer nothing is watched.
   logic [15:0] m_pipe1, m_pipe2;
   logic [15:0] m_last;          // last accepted value
   logic [15:0] m_watch;         // value currently being watched
   bit          m_watching;
   int          m_samples;       // consecutive samples of m_watch seen so far
   bit          m_pending;
   logic [3:0]  m_code;
   bit          m_multi, m_none;

   function automatic logic [3:0] ref_code(input logic [15:0] v);
      int vv;
      vv = int'(v);
      if (vv == 0) return 4'd0;
      return 4'($clog2(vv + 1) - 1);
   endfunction

   task automatic model_edge();
      logic [15:0] seen;
      if (rst) begin
         m_pipe1 = '0; m_pipe2 = '0; m_last = '0; m_watch = '0;
         m_watching = 0; m_samples = 0; m_pending = 0;
         m_code = '0; m_multi = 0; m_none = 0;
         exp_q.delete();
         return;
      end
      seen = m_pipe2;
      if (m_pending) begin
         if (ready) begin
            m_pending = 0;
            void'(exp_q.pop_front());
         end
      end else if (m_watching) begin
         if (!enable) begin
            m_watching = 0;
         end else if (seen != m_watch) begin
            m_watch   = seen;
            m_samples = 1;
         end else if (m_samples == DEBOUNCE) begin
            m_watching = 0;
            m_pending  = 1;
            m_last     = m_watch;
            m_code     = ref_code(m_watch);
            m_multi    = ($countones(m_watch) > 1);
            m_none     = (m_watch == 16'd0);
            exp_q.push_back({m_none, m_multi, m_code});
         end else begin
            m_samples++;
         end
      end else if (enable && seen != m_last) begin
         m_watching = 1;
         m_watch    = seen;
         m_samples  = 1;
      end
      m_pipe2 = m_pipe1;
      m_pipe1 = SW;
   endtask

   task automatic compare_outputs();
      check_eq("valid", 32'(valid), 32'(m_pending));
      check_eq("code", 32'(code), 32'(m_code));
      check_eq("multi", 32'(multi), 32'(m_multi));
      check_eq("none", 32'(none), 32'(m_none));
      if (valid === 1'b1 && exp_q.size() != 0)
         check_eq("result", 32'({none, multi, code}), 32'(exp_q[0]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Steps until valid is seen; idx is the edge count from the call (0-based), -1 on timeout.
   task automatic wait_valid(input int max_edges, output int idx);
      idx = -1;
      for (int k = 0; k < max_edges; k++) begin
         step();
         if (valid === 1'b1) begin
            idx = k;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int n, output int pulses);
      pulses = 0;
      for (int k = 0; k < n; k++) begin
         step();
         if (valid === 1'b1) pulses++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int idx;
      int pulses;
      int hold;
      int kind;

      // 1. Reset with all switches on.
      rst = 1'b1; SW = 16'hFFFF; enable = 1'b1; ready = 1'b1;
      run(2);
      check_eq("rst_code", 32'(code), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_multi", 32'(multi), 32'd0);
      check_eq("rst_none", 32'(none), 32'd0);
      rst = 1'b0;
      wait_valid(20, idx);
      check_eq("rst_lat", 32'(idx), 32'(DEBOUNCE + 2));
      check_eq("rst_res_code", 32'(code), 32'd15);
      check_eq("rst_res_multi", 32'(multi), 32'd1);
      run(3);

      // 2. One-hot sweep with ready high.
      for (int i = 0; i < 16; i++) begin
         SW = 16'h0001 << i;
         wait_valid(20, idx);
         check_eq("sweep_lat", 32'(idx), 32'(DEBOUNCE + 2));
         check_eq("sweep_code", 32'(code), 32'(i));
         check_eq("sweep_multi", 32'(multi), 32'd0);
         check_eq("sweep_none", 32'(none), 32'd0);
         run(13);
      end

      // 3. Bounce between 0x0000 and 0x0100, then settle on 0x0100.
      pulses = 0;
      for (int t = 0; t < 5; t++) begin
         int p;
         SW = (t % 2 == 1) ? 16'h0100 : 16'h0000;
         count_pulses(2, p);
         pulses += p;
      end
      check_eq("bounce_quiet", 32'(pulses), 32'd0);
      SW = 16'h0100;
      wait_valid(20, idx);
      check_eq("bounce_lat", 32'(idx), 32'(DEBOUNCE + 2));
      check_eq("bounce_code", 32'(code), 32'd8);
      run(4);

      // 4. Backpressure: result held while ready is low, later change queued behind it.
      ready = 1'b0; SW = 16'h8001;
      wait_valid(20, idx);
      check_eq("bp_lat", 32'(idx), 32'(DEBOUNCE + 2));
      check_eq("bp_code", 32'(code), 32'd15);
      check_eq("bp_multi", 32'(multi), 32'd1);
      run(4);
      SW = 16'h0004;
      run(8);
      check_eq("bp_hold_valid", 32'(valid), 32'd1);
      check_eq("bp_hold_code", 32'(code), 32'd15);
      ready = 1'b1;
      step();
      check_eq("bp_accept", 32'(valid), 32'd0);
      wait_valid(20, idx);
      check_eq("bp2_lat", 32'(idx), 32'(DEBOUNCE));
      check_eq("bp2_code", 32'(code), 32'd2);
      check_eq("bp2_multi", 32'(multi), 32'd0);
      run(4);

      // 5. Enable gating, then the all-zero value.
      enable = 1'b0; SW = 16'h0010;
      count_pulses(20, pulses);
      check_eq("dis_quiet", 32'(pulses), 32'd0);
      enable = 1'b1;
      wait_valid(20, idx);
      check_eq("en_lat", 32'(idx), 32'(DEBOUNCE));
      check_eq("en_code", 32'(code), 32'd4);
      run(4);
      SW = 16'h0000;
      wait_valid(20, idx);
      check_eq("zero_code", 32'(code), 32'd0);
      check_eq("zero_none", 32'(none), 32'd1);
      check_eq("zero_multi", 32'(multi), 32'd0);
      run(4);

      // 6. Reset mid-debounce, then reset while a result is waiting.
      SW = 16'h0200;
      run(5);
      rst = 1'b1;
      step();
      check_eq("mid_rst_valid", 32'(valid), 32'd0);
      rst = 1'b0; ready = 1'b0;
      wait_valid(20, idx);
      check_eq("mid_rst_lat", 32'(idx), 32'(DEBOUNCE + 2));
      check_eq("mid_rst_code", 32'(code), 32'd9);
      run(2);
      rst = 1'b1;
      step();
      check_eq("hold_rst_valid", 32'(valid), 32'd0);
      rst = 1'b0;
      wait_valid(20, idx);
      check_eq("rereport_lat", 32'(idx), 32'(DEBOUNCE + 2));
      check_eq("rereport_code", 32'(code), 32'd9);
      ready = 1'b1;
      run(3);

      // 7. Random switch activity against the model.
      for (int seg = 0; seg < 400; seg++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: SW = 16'h0001 << $urandom_range(0, 15);
            1: SW = 16'($urandom);
            2: SW = 16'h0000;
            default: SW = SW ^ (16'h0001 << $urandom_range(0, 15));
         endcase
         enable = ($urandom_range(0, 9) != 0);
         hold = $urandom_range(1, 10);
         for (int c = 0; c < hold; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
         end
         rst = 1'b0;
      end

      // Drain: stable input, ready high, everything must be consumed.
      rst = 1'b0; enable = 1'b1; ready = 1'b1;
      run(20);
      check_eq("drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
